// File: rtl/rf_pkg.sv
// Shared types and constants for the register file writeback path.
// Entry layout and scoreboard counter width live here.
package rf_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 2;
  localparam int NREG   = 4;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  typedef logic [1:0] pend_cnt_t;

endpackage

// File: rtl/wb_fifo.sv
// Writeback buffer: synchronous FIFO of wb_entry_t.
// Two ordered push slots (push1 only with push0) and one pop per cycle.
module wb_fifo
  import rf_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push0_i,
  input  logic                   push1_i,
  input  wb_entry_t              din0_i,
  input  wb_entry_t              din1_i,
  input  logic                   pop_i,
  output wb_entry_t              head_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PW = $clog2(DEPTH);

  wb_entry_t     mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d, wptr1;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW:0]   cnt_q, cnt_d;

  always_comb begin
    wptr1  = wptr_q + PW'(1);
    wptr_d = wptr_q + PW'(push0_i) + PW'(push1_i);
    rptr_d = rptr_q + PW'(pop_i);
    cnt_d  = cnt_q + (PW+1)'(push0_i)
           + (PW+1)'(push1_i) - (PW+1)'(pop_i);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push0_i) mem_q[wptr_q] <= din0_i;
    if (push1_i) mem_q[wptr1]  <= din1_i;
  end

  assign head_o  = mem_q[rptr_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Register file writer: buffers ALU/load results, drains one per cycle,
// tracks pending writes per register. Optional checker: REGFILE_WB_CHECK_EN.
module regfile_wb_ctrl
  import rf_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ld_valid,
  output logic                   ld_ready,
  input  logic [ADDR_W-1:0]      ld_rd,
  input  logic [DATA_W-1:0]      ld_data,
  input  logic                   alu_valid,
  output logic                   alu_ready,
  input  logic [ADDR_W-1:0]      alu_rd,
  input  logic [DATA_W-1:0]      alu_data,
  input  logic                   rsv_valid,
  input  logic [ADDR_W-1:0]      rsv_rd,
  output logic                   rsv_ready,
  output logic                   rf_we,
  output logic [ADDR_W-1:0]      rf_rd,
  output logic [DATA_W-1:0]      rf_din,
  output logic [NREG-1:0]        pend,
  output logic [$clog2(DEPTH):0] count
`ifdef REGFILE_WB_CHECK_EN
  ,
  output logic                   err
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic      ld_acc, alu_acc;
  logic      push0, push1, pop;
  wb_entry_t din0, din1, head;
  logic      rsv_acc;
  logic [NREG-1:0] inc, dec;
  pend_cnt_t cnt_q [NREG];
  pend_cnt_t cnt_d [NREG];

  // Load gets the last free slot; ALU needs two unless load is idle.
  assign ld_ready  = count < CW'(DEPTH);
  assign alu_ready = (count <= CW'(DEPTH - 2))
                   | (ld_ready & ~ld_valid);

  assign ld_acc  = ld_valid & ld_ready;
  assign alu_acc = alu_valid & alu_ready;

  always_comb begin
    push0 = ld_acc | alu_acc;
    push1 = ld_acc & alu_acc;
    din1  = '{rd: alu_rd, data: alu_data};
    din0  = ld_acc ? '{rd: ld_rd, data: ld_data} : din1;
  end

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push0_i (push0),
    .push1_i (push1),
    .din0_i  (din0),
    .din1_i  (din1),
    .pop_i   (pop),
    .head_o  (head),
    .count_o (count)
  );

  assign pop    = count != '0;
  assign rf_we  = pop;
  assign rf_rd  = pop ? head.rd : '0;
  assign rf_din = pop ? head.data : '0;

  assign rsv_ready = cnt_q[rsv_rd] != 2'd3;
  assign rsv_acc   = rsv_valid & rsv_ready;

  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      inc[i]   = rsv_acc && (rsv_rd == ADDR_W'(i));
      dec[i]   = pop && (head.rd == ADDR_W'(i))
               && (cnt_q[i] != 2'd0);
      cnt_d[i] = cnt_q[i];
      if (inc[i] && !dec[i])
        cnt_d[i] = cnt_q[i] + 2'd1;
      else if (dec[i] && !inc[i])
        cnt_d[i] = cnt_q[i] - 2'd1;
      pend[i]  = cnt_q[i] != 2'd0;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NREG; i++) begin
      if (rst) cnt_q[i] <= '0;
      else     cnt_q[i] <= cnt_d[i];
    end
  end

`ifdef REGFILE_WB_CHECK_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (pop && cnt_q[head.rd] == 2'd0) err_d = 1'b1;
    if (rsv_valid && !rsv_ready)       err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign err = err_q;
`endif

endmodule
